fractran_program_store: RTL

Upstream feeder for the Fractran core. Loads a Fractran program (ordered list of numerator/denominator pairs) over a byte-serial load port, then presents fractions to the core one at a time. Uses a valid/ready handshake with hit/miss feedback from the core. Applies Fractran scan order: restart at fraction 0 after a hit, advance after a miss, halt after a miss on the last fraction.

---
 rtl/fractran_pkg.sv | 21 ++
 rtl/fractran_program_store_if.sv | 22 ++
 rtl/fractran_prog_mem.sv | 32 +++
 rtl/fractran_program_store.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fractran_pkg.sv
// Shared types and defaults for the Fractran program store.
package fractran_pkg;

  localparam int DEF_W         = 8;
  localparam int DEF_MAX_FRACS = 16;

  typedef enum logic [2:0] {
    LOAD_COUNT,
    LOAD_NUM,
    LOAD_DEN,
    READY,
    RUN,
    HALTED
  } state_t;

  typedef struct packed {
    logic [DEF_W-1:0] num;
    logic [DEF_W-1:0] den;
  } frac_t;

endpackage

// File: rtl/fractran_program_store_if.sv
// Fraction handshake between the program store (master) and the Fractran core (slave).
interface fractran_program_store_if #(
  parameter int W     = 8,
  parameter int IDX_W = 4
);
  logic             frac_valid;
  logic             frac_ready;
  logic             frac_hit;
  logic [W-1:0]     frac_num;
  logic [W-1:0]     frac_den;
  logic [IDX_W-1:0] frac_idx;

  modport master (
    output frac_valid, frac_num, frac_den, frac_idx,
    input  frac_ready, frac_hit
  );

  modport slave (
    input  frac_valid, frac_num, frac_den, frac_idx,
    output frac_ready, frac_hit
  );
endinterface

// File: rtl/fractran_prog_mem.sv
// Program register file: one synchronous write port, one combinational read port.
module fractran_prog_mem #(
  parameter int W         = 8,
  parameter int MAX_FRACS = 16,
  parameter int IDX_W     = $clog2(MAX_FRACS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wnum,
  input  logic [W-1:0]     wden,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     num,
  output logic [W-1:0]     den
);

  logic [W-1:0] num_mem [MAX_FRACS];
  logic [W-1:0] den_mem [MAX_FRACS];

  // Write one whole fraction per enabled cycle.
  // NOTE: the array has no reset; contents only matter once a program is loaded.
  always_ff @(posedge clk) begin
    if (we) begin
      num_mem[waddr] <= wnum;
      den_mem[waddr] <= wden;
    end
  end

  assign num = num_mem[raddr];
  assign den = den_mem[raddr];

endmodule

// File: rtl/fractran_program_store.sv
// Loads a Fractran program byte-serially, then feeds fractions to the core in scan order.
module fractran_program_store
  import fractran_pkg::*;
#(
  parameter int MAX_FRACS = DEF_MAX_FRACS,
  parameter int W         = DEF_W,
  localparam int IDX_W    = $clog2(MAX_FRACS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          load_valid,
  input  logic [7:0]                    load_data,
  input  logic                          start,
  fractran_program_store_if.master      fif,
  output logic [IDX_W:0]                count,
  output logic                          loaded,
  output logic                          halt,
  output logic                          err
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] widx_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W:0]   count_q;
  logic [W-1:0]     num_hold_q;
  logic             loaded_q, halt_q, err_q;

  logic count_ok, den_zero, widx_last, idx_last, handshake, mem_we;

  assign count_ok  = (load_data != 8'd0) && (int'(load_data) <= MAX_FRACS);
  assign den_zero  = (load_data == 8'd0);
  assign widx_last = ({1'b0, widx_q} == count_q - 1'b1);
  assign idx_last  = ({1'b0, idx_q} == count_q - 1'b1);
  assign handshake = en && (state_q == RUN) && fif.frac_ready;

  // Next-state decode and write strobe; every transition is qualified by en.
  // NOTE: defaults first so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    if (en) begin
      unique case (state_q)
        LOAD_COUNT: if (load_valid && count_ok) state_d = LOAD_NUM;
        LOAD_NUM:   if (load_valid) state_d = LOAD_DEN;
        LOAD_DEN: begin
          if (load_valid) begin
            if (den_zero) begin
              state_d = LOAD_COUNT;
            end else begin
              mem_we  = 1'b1;
              state_d = widx_last ? READY : LOAD_NUM;
            end
          end
        end
        READY, HALTED: if (start) state_d = RUN;
        RUN: if (handshake && !fif.frac_hit && idx_last) state_d = HALTED;
        default: state_d = LOAD_COUNT;
      endcase
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD_COUNT;
    else     state_q <= state_d;
  end

  // Count, write index, scan index and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      widx_q     <= '0;
      idx_q      <= '0;
      num_hold_q <= '0;
      loaded_q   <= 1'b0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (en) begin
      unique case (state_q)
        LOAD_COUNT: begin
          if (load_valid) begin
            if (count_ok) begin
              count_q <= load_data[IDX_W:0];
              widx_q  <= '0;
              err_q   <= 1'b0;
            end else begin
              err_q   <= 1'b1;
            end
          end
        end
        LOAD_NUM: if (load_valid) num_hold_q <= load_data[W-1:0];
        LOAD_DEN: begin
          if (load_valid) begin
            if (den_zero) begin
              err_q    <= 1'b1;
              loaded_q <= 1'b0;
            end else if (widx_last) begin
              loaded_q <= 1'b1;
            end else begin
              widx_q   <= widx_q + 1'b1;
            end
          end
        end
        READY, HALTED: begin
          if (start) begin
            idx_q  <= '0;
            halt_q <= 1'b0;
          end
        end
        RUN: begin
          if (handshake) begin
            if (fif.frac_hit) idx_q  <= '0;
            else if (!idx_last) idx_q <= idx_q + 1'b1;
            else halt_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  fractran_prog_mem #(
    .W         (W),
    .MAX_FRACS (MAX_FRACS),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (widx_q),
    .wnum  (num_hold_q),
    .wden  (load_data[W-1:0]),
    .raddr (idx_q),
    .num   (fif.frac_num),
    .den   (fif.frac_den)
  );

  assign fif.frac_valid = (state_q == RUN);
  assign fif.frac_idx   = idx_q;
  assign count          = count_q;
  assign loaded         = loaded_q;
  assign halt           = halt_q;
  assign err            = err_q;

endmodule
